// File: rtl/i2s_pkg.sv
`timescale 1ns/1ps
// i2s_pkg: constants and types shared by the I2S reader and writer blocks.
package i2s_pkg;

  // Default slot length in bit clocks, and default captured bits per sample.
  localparam int DATA_SIZE_DEF    = 32;
  localparam int SAMPLE_WIDTH_DEF = 24;

  // Word select polarity: low selects the left channel, high selects the right.
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  // Receiver word-framing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
`timescale 1ns/1ps
// i2s_sync_edge: brings an asynchronous level into the clk domain through two
// flops and produces a registered one-cycle strobe on its rising edge.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_strobe
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Two-stage synchronizer, a delayed copy, and the registered rising-edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      rise_strobe <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], async_in};
      prev_q      <= sync_q[1];
      rise_strobe <= sync_q[1] & ~prev_q;
    end
  end

endmodule

// File: rtl/i2s_reader.sv
`timescale 1ns/1ps
// i2s_reader: oversamples an I2S stream on the system clock, frames each channel
// word, and hands complete samples to a consumer through a valid/ack register.
module i2s_reader
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    i2s_clock,
  input  logic                    i2s_lr,
  input  logic                    i2s_data,
  output logic                    audio_data_valid,
  input  logic                    audio_data_ack,
  output logic [SAMPLE_WIDTH-1:0] audio_data,
  output logic                    audio_lr_bit,
  output logic                    overrun,
  output logic                    frame_error
);

  localparam int CNT_W = $clog2(DATA_SIZE);

  logic [1:0]              rst_sync_q;
  logic                    rst_n_int;
  logic [1:0]              lr_sync_q;
  logic [1:0]              data_sync_q;
  logic                    strobe;
  logic                    lr_s;
  logic                    data_s;
  logic                    lr_prev_q;
  logic                    lr_primed_q;
  logic                    lr_edge;

  rx_state_t               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    word_lr_q, word_lr_d;
  logic                    complete;
  logic                    trunc;

  // Reset asserts immediately but releases only on a clk edge, two flops later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  i2s_sync_edge u_bclk_sync (
    .clk         (clk),
    .rst_n       (rst_n_int),
    .async_in    (i2s_clock),
    .rise_strobe (strobe)
  );

  // Word select and data get the same synchronizer depth as the bit clock.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      lr_sync_q   <= '0;
      data_sync_q <= '0;
    end else begin
      lr_sync_q   <= {lr_sync_q[0], i2s_lr};
      data_sync_q <= {data_sync_q[0], i2s_data};
    end
  end

  assign lr_s   = lr_sync_q[1];
  assign data_s = data_sync_q[1];

  // Track word select at every strobe, even while disabled, so a re-enable
  // waits for a genuine transition; the first strobe after reset only primes.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      lr_prev_q   <= 1'b0;
      lr_primed_q <= 1'b0;
    end else if (strobe) begin
      lr_prev_q   <= lr_s;
      lr_primed_q <= 1'b1;
    end
  end

  assign lr_edge = strobe & lr_primed_q & (lr_s != lr_prev_q);

  // Framing state, bit counter, shifter and the channel of the word in flight.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      word_lr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      word_lr_q <= word_lr_d;
    end
  end

  // Next-state logic: an LR edge always starts a new word, and one arriving
  // before the sample is full aborts the partial word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_lr_d = word_lr_q;
    complete  = 1'b0;
    trunc     = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else if (strobe) begin
      unique case (state_q)
        ST_IDLE, ST_PAD: begin
          if (lr_edge) begin
            state_d   = ST_SKIP;
            word_lr_d = lr_s;
          end
        end
        ST_SKIP: begin
          if (lr_edge) begin
            trunc     = 1'b1;
            word_lr_d = lr_s;
          end else begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        ST_SHIFT: begin
          if (lr_edge) begin
            trunc     = 1'b1;
            state_d   = ST_SKIP;
            word_lr_d = lr_s;
            cnt_d     = '0;
            shift_d   = '0;
          end else begin
            shift_d = {shift_q[SAMPLE_WIDTH-2:0], data_s};
            if (cnt_q == CNT_W'(SAMPLE_WIDTH - 1)) begin
              complete = 1'b1;
              state_d  = ST_PAD;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Holding register with valid/ack handshake, sticky overrun and the
  // one-cycle truncation pulse.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      audio_data_valid <= 1'b0;
      audio_data       <= '0;
      audio_lr_bit     <= 1'b0;
      overrun          <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      frame_error <= trunc;
      if (!enable) begin
        overrun <= 1'b0;
      end
      if (complete) begin
        if (!audio_data_valid || audio_data_ack) begin
          audio_data       <= shift_d;
          audio_lr_bit     <= word_lr_q;
          audio_data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (audio_data_valid && audio_data_ack) begin
        audio_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_reader.sv
`timescale 1ns/1ps
// tb_i2s_reader: drives I2S slots into the reader and compares delivered
// samples, flags and pulses against what each transmitted slot should yield.
module tb_i2s_reader;
  import i2s_pkg::*;

  localparam int I2S_HALF = 4;   // clk cycles per half bit-clock period
  localparam int SLOT     = 32;
  localparam int SW       = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        i2s_clock;
  logic        i2s_lr;
  logic        i2s_data;
  logic        audio_data_valid;
  logic        audio_data_ack;
  logic [23:0] audio_data;
  logic        audio_lr_bit;
  logic        overrun;
  logic        frame_error;

  logic        auto_ack   = 1'b0;
  logic        man_ack;
  logic        consume_en;
  logic        valid_prev = 1'b0;
  logic        fe_prev    = 1'b0;

  int          checks     = 0;
  int          failures   = 0;
  int          cyc        = 0;
  int          last_rise_cyc;
  int          latency    = -1;
  int          fe_pulses  = 0;
  int          fe_cycles  = 0;
  int          rx_base;
  int          exp_base;
  int          fe_base_p;
  int          fe_base_c;

  logic [24:0] rx_q[$];
  logic [24:0] exp_q[$];

  assign audio_data_ack = auto_ack | man_ack;

  i2s_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .i2s_clock        (i2s_clock),
    .i2s_lr           (i2s_lr),
    .i2s_data         (i2s_data),
    .audio_data_valid (audio_data_valid),
    .audio_data_ack   (audio_data_ack),
    .audio_data       (audio_data),
    .audio_lr_bit     (audio_lr_bit),
    .overrun          (overrun),
    .frame_error      (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and auto-consumer: latency of each valid rise, frame_error pulses,
  // and a one-cycle ack for every sample seen while consuming.
  always @(negedge clk) begin
    if (audio_data_valid && !valid_prev) latency = cyc - last_rise_cyc;
    valid_prev = audio_data_valid;
    if (frame_error) begin
      fe_cycles++;
      if (!fe_prev) fe_pulses++;
    end
    fe_prev = frame_error;
    if (consume_en && audio_data_valid && !auto_ack) begin
      rx_q.push_back({audio_lr_bit, audio_data});
      auto_ack = 1'b1;
    end else begin
      auto_ack = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One I2S slot: bit 0 carries the word-select change, bit 1 is the delay bit,
  // bits 2..25 carry the sample MSB first, the rest is filler. Optional events:
  // enable off/on, a one-cycle reset pulse, and an ack during the completion cycle.
  task automatic apply_stimulus(input logic lr, input logic [23:0] value, input int nbits,
                                input int off_pos, input int on_pos, input int rst_pos,
                                input bit ack_last);
    logic bit_val;
    for (int pos = 0; pos < nbits; pos++) begin
      if (pos == off_pos) enable = 1'b0;
      if (pos == on_pos) enable = 1'b1;
      if (pos >= 2 && pos < 2 + SW) bit_val = value[SW + 1 - pos];
      else bit_val = 1'($urandom);
      i2s_clock = 1'b0;
      i2s_lr    = lr;
      i2s_data  = bit_val;
      if (pos == rst_pos) begin
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_valid", audio_data_valid, 1'b0);
        check_output("rst_mid_data", audio_data, 24'h0);
        check_output("rst_mid_lr", audio_lr_bit, 1'b0);
        check_output("rst_mid_overrun", overrun, 1'b0);
        check_output("rst_mid_frame_error", frame_error, 1'b0);
      end
      for (int k = 0; k < I2S_HALF; k++) begin
        @(negedge clk);
        if (pos == rst_pos && k == 0) rst_n = 1'b1;
      end
      i2s_clock = 1'b1;
      if (pos == SW + 1) last_rise_cyc = cyc;
      for (int k = 1; k <= I2S_HALF; k++) begin
        @(negedge clk);
        man_ack = ack_last && (pos == SW + 1) && (k == 3);
      end
    end
  endtask

  task automatic send_word(input logic lr, input logic [23:0] value);
    apply_stimulus(lr, value, SLOT, -1, -1, -1, 1'b0);
  endtask

  task automatic mark_scoreboard();
    rx_base   = rx_q.size();
    exp_base  = exp_q.size();
    fe_base_p = fe_pulses;
    fe_base_c = fe_cycles;
  endtask

  task automatic check_scoreboard(input string tag);
    int n_rx;
    int n_exp;
    n_rx  = rx_q.size() - rx_base;
    n_exp = exp_q.size() - exp_base;
    check_output({tag, "_count"}, n_rx, n_exp);
    for (int k = 0; k < n_exp && k < n_rx; k++)
      check_output($sformatf("%s_word%0d", tag, k), 32'(rx_q[rx_base + k]), 32'(exp_q[exp_base + k]));
  endtask

  task automatic pulse_ack();
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
  endtask

  initial begin
    logic [23:0] v1;
    logic [23:0] v2;
    logic [23:0] v3;
    logic        lr;
    $display("[TB] start");
    rst_n      = 1'b0;
    enable     = 1'b0;
    i2s_clock  = 1'b0;
    i2s_lr     = LR_RIGHT;
    i2s_data   = 1'b0;
    man_ack    = 1'b0;
    consume_en = 1'b0;
    last_rise_cyc = 0;
    repeat (4) @(negedge clk);

    // Reset state
    check_output("reset_valid", audio_data_valid, 1'b0);
    check_output("reset_data", audio_data, 24'h0);
    check_output("reset_lr", audio_lr_bit, 1'b0);
    check_output("reset_overrun", overrun, 1'b0);
    check_output("reset_frame_error", frame_error, 1'b0);

    rst_n  = 1'b1;
    enable = 1'b1;
    send_word(LR_RIGHT, 24'h0);   // idle right slot, no edge

    // Left then right directed words with a prompt consumer
    consume_en = 1'b1;
    mark_scoreboard();
    send_word(LR_LEFT, 24'hA5C3F1);
    exp_q.push_back({LR_LEFT, 24'hA5C3F1});
    check_output($sformatf("latency_4_or_5_got_%0d", latency), (latency == 4 || latency == 5), 1'b1);
    send_word(LR_RIGHT, 24'h123456);
    exp_q.push_back({LR_RIGHT, 24'h123456});
    repeat (10) @(negedge clk);
    check_scoreboard("lr_pair");
    check_output("lr_pair_overrun", overrun, 1'b0);
    check_output("lr_pair_fe", fe_pulses - fe_base_p, 0);

    // Random words, alternating channels
    mark_scoreboard();
    for (int i = 0; i < 6; i++) begin
      lr = (i % 2 == 0) ? LR_LEFT : LR_RIGHT;
      v1 = 24'($urandom);
      send_word(lr, v1);
      exp_q.push_back({lr, v1});
    end
    repeat (10) @(negedge clk);
    check_scoreboard("random");
    check_output("random_overrun", overrun, 1'b0);

    // No consumer: first sample held, later ones dropped, overrun sticky
    consume_en = 1'b0;
    v1 = 24'($urandom);
    v2 = 24'($urandom);
    v3 = 24'($urandom);
    send_word(LR_LEFT, v1);
    send_word(LR_RIGHT, v2);
    check_output("hold_valid", audio_data_valid, 1'b1);
    check_output("hold_data", audio_data, v1);
    check_output("hold_lr", audio_lr_bit, LR_LEFT);
    check_output("hold_overrun", overrun, 1'b1);
    send_word(LR_LEFT, v3);
    check_output("hold_overrun_sticky", overrun, 1'b1);
    check_output("hold_data_kept", audio_data, v1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_output("disable_overrun_clr", overrun, 1'b0);
    check_output("disable_valid_kept", audio_data_valid, 1'b1);
    check_output("disable_data_kept", audio_data, v1);
    enable = 1'b1;
    pulse_ack();
    check_output("ack_clears_valid", audio_data_valid, 1'b0);

    // Ack in the same cycle the next word completes
    v1 = 24'($urandom);
    send_word(LR_RIGHT, v1);
    check_output("ackcomp_pre_data", audio_data, v1);
    apply_stimulus(LR_LEFT, 24'h000001, SLOT, -1, -1, -1, 1'b1);
    check_output("ackcomp_valid", audio_data_valid, 1'b1);
    check_output("ackcomp_data", audio_data, 24'h000001);
    check_output("ackcomp_lr", audio_lr_bit, LR_LEFT);
    check_output("ackcomp_overrun", overrun, 1'b0);
    pulse_ack();

    // Word select toggles after 10 data bits
    consume_en = 1'b1;
    mark_scoreboard();
    apply_stimulus(LR_RIGHT, 24'($urandom), 12, -1, -1, -1, 1'b0);
    send_word(LR_LEFT, 24'hFFFFFF);
    exp_q.push_back({LR_LEFT, 24'hFFFFFF});
    repeat (10) @(negedge clk);
    check_output("trunc_fe_pulses", fe_pulses - fe_base_p, 1);
    check_output("trunc_fe_cycles", fe_cycles - fe_base_c, 1);
    check_scoreboard("trunc");

    // Enable dropped and restored mid-word
    mark_scoreboard();
    apply_stimulus(LR_RIGHT, 24'($urandom), SLOT, 8, 16, -1, 1'b0);
    send_word(LR_LEFT, 24'h800000);
    exp_q.push_back({LR_LEFT, 24'h800000});
    repeat (10) @(negedge clk);
    check_scoreboard("reenable");
    check_output("reenable_fe", fe_pulses - fe_base_p, 0);

    // Reset pulse mid-word, with a held sample and overrun set beforehand
    consume_en = 1'b0;
    send_word(LR_RIGHT, 24'($urandom));
    send_word(LR_LEFT, 24'($urandom));
    check_output("prereset_overrun", overrun, 1'b1);
    mark_scoreboard();
    apply_stimulus(LR_RIGHT, 24'($urandom), SLOT, -1, -1, 10, 1'b0);
    consume_en = 1'b1;
    v1 = 24'($urandom);
    send_word(LR_LEFT, v1);
    exp_q.push_back({LR_LEFT, v1});
    repeat (10) @(negedge clk);
    check_scoreboard("postreset");
    check_output("postreset_fe", fe_pulses - fe_base_p, 0);
    check_output("postreset_overrun", overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
